// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, frame results and key identifiers.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressDeb,
        StHeld,
        StRelDeb
    } state_e;

    typedef enum logic [1:0] {
        FrNone,
        FrSingle,
        FrMulti
    } frame_e;

    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_SHARP = 4'hF;

    // Keypad layout: r0 "123A", r1 "456B", r2 "789C", r3 "*0#D".
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'h0;
            4'd14:   code = KEY_SHARP;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side signals and key event outputs of the scanner.
interface keypad_scan_if;

    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       star;
    logic       sharp;

    modport master (
        output row_in,
        input  col_out,
        input  key_valid,
        input  key_code,
        input  star,
        input  sharp
    );

    modport slave (
        input  row_in,
        output col_out,
        output key_valid,
        output key_code,
        output star,
        output sharp
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, cleared by the synchronous reset.
module sync_2ff #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based debounce and single-shot key events.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic         clk,
    input  logic         rst,
    keypad_scan_if.slave kp
);

    import keypad_scan_pkg::*;

    localparam logic [15:0] DwellLast = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DebCount  = 4'(DEBOUNCE);

    logic [3:0]  w_row;
    logic [15:0] r_dwell;
    logic [1:0]  r_col;
    logic        w_col_end;
    logic        w_frame_end;

    sync_2ff #(
        .WIDTH    (4),
        .RESET_VAL(4'hF)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(kp.row_in),
        .o_q(w_row)
    );

    assign w_col_end   = (r_dwell == DwellLast);
    assign w_frame_end = w_col_end && (r_col == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
            r_col   <= '0;
        end else if (w_col_end) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
        end else begin
            r_dwell <= r_dwell + 16'd1;
        end
    end

    assign kp.col_out = ~(4'b0001 << r_col);

    // Per-column hit count; hit count is saturated at 2 across the frame (2 means MULTI).
    logic [2:0] w_col_hits;
    logic [1:0] w_hit_row;
    logic [1:0] r_hits;
    logic [3:0] r_key;
    logic [2:0] w_hits_sum;
    logic [1:0] w_hits_acc;
    logic [3:0] w_key_acc;
    frame_e     w_frame;

    always_comb begin
        w_col_hits = '0;
        w_hit_row  = '0;
        for (int i = 0; i < 4; i++) begin
            if (!w_row[i]) begin
                w_col_hits = w_col_hits + 3'd1;
                w_hit_row  = 2'(i);
            end
        end
    end

    assign w_hits_sum = {1'b0, r_hits} + w_col_hits;
    assign w_hits_acc = (w_hits_sum > 3'd2) ? 2'd2 : w_hits_sum[1:0];
    assign w_key_acc  = (w_col_hits == 3'd1) ? key_map(w_hit_row, r_col) : r_key;
    assign w_frame    = (w_hits_acc == 2'd0) ? FrNone :
                        (w_hits_acc == 2'd1) ? FrSingle : FrMulti;

    always_ff @(posedge clk) begin
        if (rst || w_frame_end) begin
            r_hits <= '0;
            r_key  <= '0;
        end else if (w_col_end) begin
            r_hits <= w_hits_acc;
            r_key  <= w_key_acc;
        end
    end

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic [3:0] r_cand;
    logic [3:0] w_cand_next;
    logic       w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_accept     = 1'b0;
        if (w_frame_end) begin
            unique case (r_state)
                StIdle: begin
                    if (w_frame == FrSingle) begin
                        w_cand_next = w_key_acc;
                        w_cnt_next  = 4'd1;
                        if (DEBOUNCE <= 1) begin
                            w_accept     = 1'b1;
                            w_state_next = StHeld;
                        end else begin
                            w_state_next = StPressDeb;
                        end
                    end
                end
                StPressDeb: begin
                    if (w_frame != FrSingle) begin
                        w_state_next = StIdle;
                    end else if (w_key_acc == r_cand) begin
                        w_cnt_next = r_cnt + 4'd1;
                        if (w_cnt_next >= DebCount) begin
                            w_accept     = 1'b1;
                            w_state_next = StHeld;
                        end
                    end else begin
                        w_cand_next = w_key_acc;
                        w_cnt_next  = 4'd1;
                    end
                end
                StHeld: begin
                    if (w_frame == FrNone) begin
                        w_cnt_next   = 4'd1;
                        w_state_next = (DEBOUNCE <= 1) ? StIdle : StRelDeb;
                    end
                end
                StRelDeb: begin
                    if (w_frame == FrNone) begin
                        w_cnt_next = r_cnt + 4'd1;
                        if (w_cnt_next >= DebCount) begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_state_next = StHeld;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    logic       r_key_valid;
    logic       r_star;
    logic       r_sharp;
    logic [3:0] r_key_code;
    logic       w_is_star;
    logic       w_is_sharp;

    assign w_is_star  = (w_key_acc == KEY_STAR);
    assign w_is_sharp = (w_key_acc == KEY_SHARP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid <= 1'b0;
            r_star      <= 1'b0;
            r_sharp     <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= w_accept && !w_is_star && !w_is_sharp;
            r_star      <= w_accept && w_is_star;
            r_sharp     <= w_accept && w_is_sharp;
            if (w_accept && !w_is_star && !w_is_sharp) begin
                r_key_code <= w_key_acc;
            end
        end
    end

    assign kp.key_valid = r_key_valid;
    assign kp.star      = r_star;
    assign kp.sharp     = r_sharp;
    assign kp.key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=2) with a behavioural key matrix.
module tb_keypad_scan;

    localparam logic [15:0] K1    = 16'h0001;
    localparam logic [15:0] K2    = 16'h0002;
    localparam logic [15:0] KA    = 16'h0008;
    localparam logic [15:0] K5    = 16'h0020;
    localparam logic [15:0] K7    = 16'h0100;
    localparam logic [15:0] KSTAR = 16'h1000;
    localparam logic [15:0] KSHRP = 16'h4000;

    localparam logic [2:0] EvKey   = 3'b100;
    localparam logic [2:0] EvStar  = 3'b010;
    localparam logic [2:0] EvSharp = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] code;
        int         at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    int          cyc = 0;
    int          fr = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb_q[$];

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif.slave)
    );

    always #5 clk = ~clk;

    // Pressed key shorts its row to the column currently driven low.
    always_comb begin
        kif.row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            kif.row_in[r] = ~|(keys[r*4 +: 4] & ~kif.col_out);
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [3:0] code, input int frame_end);
        exp_t e;
        e.kind = kind;
        e.code = code;
        e.at   = 16 * frame_end;
        sb_q.push_back(e);
    endtask

    task automatic frames(input logic [15:0] m, input int n);
        logic [3:0] col_exp;
        keys = m;
        repeat (16 * n) begin
            @(negedge clk);
            col_exp = ~(4'b0001 << ((cyc / 4) % 4));
            chk("col_out", {28'd0, kif.col_out}, {28'd0, col_exp});
        end
        fr += n;
    endtask

    task automatic check_reset_outputs();
        chk("rst_col_out", {28'd0, kif.col_out}, 32'h0000_000E);
        chk("rst_pulses", {29'd0, kif.key_valid, kif.star, kif.sharp}, 32'd0);
        chk("rst_key_code", {28'd0, kif.key_code}, 32'd0);
    endtask

    always @(negedge clk) begin
        logic [2:0] kind;
        exp_t       e;
        if (rst === 1'b0) begin
            kind = {kif.key_valid, kif.star, kif.sharp};
            if (kind != 3'b000) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_pulse", {29'd0, kind}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_kind", {29'd0, kind}, {29'd0, e.kind});
                    chk("pulse_cycle", cyc, e.at);
                    if (e.kind == EvKey) chk("key_code", {28'd0, kif.key_code}, {28'd0, e.code});
                end
            end
        end
    end

    initial begin
        keys = '0;
        rst  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst = 1'b0;
        fr  = 0;

        // Idle scanning, no pulses.
        frames('0, 13);

        // '5' held 10 frames: a single pulse at the end of the second contact frame.
        push(EvKey, 4'h5, fr + 2);
        frames(K5, 10);
        frames('0, 4);

        // '*' then '#'.
        push(EvStar, 4'h0, fr + 2);
        frames(KSTAR, 4);
        frames('0, 4);
        push(EvSharp, 4'h0, fr + 2);
        frames(KSHRP, 4);
        frames('0, 4);

        // Bouncing '7', then a steady hold.
        frames(K7, 1);
        frames('0, 1);
        push(EvKey, 4'h7, fr + 2);
        frames(K7, 4);
        frames('0, 4);

        // '1'+'2' together is ignored; releasing '2' leaves a clean '1'.
        frames(K1 | K2, 5);
        push(EvKey, 4'h1, fr + 2);
        frames(K1, 4);
        frames('0, 4);

        // Reset in the middle of the first contact frame of 'A'.
        keys = KA;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        fr  = 0;
        push(EvKey, 4'hA, fr + 2);
        frames(KA, 4);
        frames('0, 4);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
